// File: rtl/mr_wb_timer_pkg.sv
// Shared constants and types for the Wishbone machine timer (mtime/mtimecmp).
// Word-index map, control-register layout and a byte-lane merge helper.
package mr_timer_pkg;

  localparam int XLEN      = 32;
  localparam int XLEN_GRAN = 2;
  localparam int ADR_W     = XLEN - XLEN_GRAN;
  localparam int SEL_W     = XLEN / 8;

  localparam logic [2:0] TMR_IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] TMR_IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] TMR_IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] TMR_IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] TMR_IDX_CTRL     = 3'd4;
  localparam logic [2:0] TMR_IDX_PRESCALE = 3'd5;

  localparam int          CTRL_EN_BIT  = 0;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic en;
  } tmr_ctrl_t;

  function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] wdat,
                                                  input logic [SEL_W-1:0] sel);
    logic [XLEN-1:0] res;
    res = old_v;
    for (int b = 0; b < SEL_W; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mr_wb_timer_if.sv
// Wishbone pipelined-mode bus bundle between an initiator and the timer.
interface mr_wb_timer_if;
  import mr_timer_pkg::*;

  logic [ADR_W-1:0] adr_i;
  logic [XLEN-1:0]  dat_i;
  logic [SEL_W-1:0] sel_i;
  logic             we_i;
  logic             stb_i;
  logic             cyc_i;
  logic [XLEN-1:0]  dat_o;
  logic             ack_o;
  logic             err_o;
  logic             stall_o;

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o, stall_o
  );

  modport master (
    output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o, stall_o
  );

endinterface

// File: rtl/mr_wb_timer_prescaler.sv
// Tick generator: down-counter that fires at zero and reloads the prescale value.
module mr_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_load,
  input  logic [PRESCALE_W-1:0] i_value,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);
  logic [PRESCALE_W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  // A prescale write restarts the count from the new value straight away.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (o_tick) r_cnt <= i_prescale;
    else             r_cnt <= r_cnt - 1'b1;
  end

endmodule

// File: rtl/mr_wb_timer.sv
// Wishbone machine timer: 64-bit mtime/mtimecmp, tear-free hi read via shadow, level irq.
// Optional tick prescaler enabled by defining MR_TIMER_PRESCALE_EN.
module mr_wb_timer
  import mr_timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mr_wb_timer_if.slave bus,
  output logic         irq_o
);
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic [XLEN-1:0] r_shadow;
  logic [XLEN-1:0] r_dat;
  tmr_ctrl_t       r_ctrl;
  logic            r_ack;
  logic            r_err;
  logic            r_irq;

  logic [2:0]      w_idx;
  logic            w_acc;
  logic            w_rd;
  logic            w_wr;
  logic            w_mapped;
  logic            w_tick;
  logic [XLEN-1:0] w_rdata;
  logic [63:0]     w_mtime_nxt;
  logic            w_unused;

  assign w_idx    = bus.adr_i[2:0];
  assign w_acc    = bus.cyc_i & bus.stb_i;
  assign w_rd     = w_acc & ~bus.we_i & w_mapped;
  assign w_wr     = w_acc & bus.we_i & w_mapped;
  assign w_unused = ^bus.adr_i[ADR_W-1:3];

`ifdef MR_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic                  w_ps_load;

  assign w_ps_load      = w_wr && (w_idx == TMR_IDX_PRESCALE);
  assign w_prescale_nxt = PRESCALE_W'(merge_lanes(XLEN'(r_prescale), bus.dat_i, bus.sel_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         r_prescale <= '0;
    else if (w_ps_load) r_prescale <= w_prescale_nxt;
  end

  mr_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_load     (w_ps_load),
    .i_value    (w_prescale_nxt),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );
`else
  logic [PRESCALE_W-1:0] w_unused_ps;
  assign w_unused_ps = '0;
  assign w_tick      = 1'b1;
`endif

  always_comb begin
    w_mapped = (w_idx <= TMR_IDX_CTRL);
`ifdef MR_TIMER_PRESCALE_EN
    if (w_idx == TMR_IDX_PRESCALE) w_mapped = 1'b1;
`endif
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      TMR_IDX_MTIME_LO: w_rdata = r_mtime[31:0];
      TMR_IDX_MTIME_HI: w_rdata = r_shadow;
      TMR_IDX_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      TMR_IDX_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      TMR_IDX_CTRL:     w_rdata[CTRL_EN_BIT] = r_ctrl.en;
`ifdef MR_TIMER_PRESCALE_EN
      TMR_IDX_PRESCALE: w_rdata = XLEN'(r_prescale);
`endif
      default: ;
    endcase
  end

  // A bus write to either mtime half pre-empts that cycle's increment.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && (w_idx == TMR_IDX_MTIME_LO))
      w_mtime_nxt[31:0] = merge_lanes(r_mtime[31:0], bus.dat_i, bus.sel_i);
    else if (w_wr && (w_idx == TMR_IDX_MTIME_HI))
      w_mtime_nxt[63:32] = merge_lanes(r_mtime[63:32], bus.dat_i, bus.sel_i);
    else if (r_ctrl.en && w_tick)
      w_mtime_nxt = r_mtime + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= MTIMECMP_RST;
      r_ctrl     <= '0;
      r_shadow   <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      r_irq   <= (r_mtime >= r_mtimecmp);
      if (w_wr && (w_idx == TMR_IDX_CMP_LO))
        r_mtimecmp[31:0] <= merge_lanes(r_mtimecmp[31:0], bus.dat_i, bus.sel_i);
      if (w_wr && (w_idx == TMR_IDX_CMP_HI))
        r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], bus.dat_i, bus.sel_i);
      if (w_wr && (w_idx == TMR_IDX_CTRL) && bus.sel_i[0])
        r_ctrl.en <= bus.dat_i[CTRL_EN_BIT];
      // Shadow freezes the high half at the low-half read so a following hi read is consistent.
      if (w_wr && (w_idx == TMR_IDX_MTIME_HI))
        r_shadow <= w_mtime_nxt[63:32];
      else if (w_rd && (w_idx == TMR_IDX_MTIME_LO))
        r_shadow <= r_mtime[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc & w_mapped;
      r_err <= w_acc & ~w_mapped;
      r_dat <= w_rd ? w_rdata : '0;
    end
  end

  // An initiator that drops cyc_i in the response cycle has abandoned the cycle.
  assign bus.ack_o   = r_ack & bus.cyc_i;
  assign bus.err_o   = r_err & bus.cyc_i;
  assign bus.dat_o   = r_dat;
  assign bus.stall_o = 1'b0;
  assign irq_o       = r_irq;

endmodule
